// File: rtl/riscv_pkg.sv
// RISC-V architectural types shared across the core.
// Only the address type is needed by the BTB update path.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/tortoise_pkg.sv
// Core-level parameters and bundles for the tortoise frontend.
// Holds the BTB update record and its buffer depth.
package tortoise_pkg;

  localparam int BTB_UPD_FIFO_DEPTH = 4;

  typedef struct packed {
    riscv_pkg::addr_t pc;
    riscv_pkg::addr_t target;
  } btb_update_t;

  function automatic logic [1:0] cnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Dual-write, single-read in-order FIFO of BTB updates.
// Port 0 is written before port 1 when both push.
module btb_update_fifo
  import tortoise_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [1:0]            push_i,
  input  btb_update_t [1:0]     data_i,
  input  logic                  pop_i,
  output btb_update_t           head_o,
  output logic [CW-1:0]         count_o
);

  btb_update_t       mem_q [DEPTH];
  logic [PW-1:0]     rptr_q;
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     wptr1;
  logic [CW-1:0]     count_q;
  logic [1:0]        push;
  logic [1:0]        n_push;

  assign push   = push_i & {2{~clear_i}};
  assign n_push = cnt2(push);
  assign wptr1  = wptr_q + PW'(push[0]);

  // Storage writes; port 1 lands behind port 0 when both push.
  always_ff @(posedge clk_i) begin
    if (push[0]) mem_q[wptr_q] <= data_i[0];
    if (push[1]) mem_q[wptr1]  <= data_i[1];
  end

  // Pointers and occupancy; clear empties the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_q + PW'(pop_i);
      wptr_q  <= wptr_q + PW'(n_push);
      count_q <= count_q + CW'(n_push) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/btb_update_arbiter.sv
// Sequencer for the BTB fallback write port: two-requester
// round-robin intake, buffered drain, debug drop and flush.
module btb_update_arbiter
  import riscv_pkg::*;
  import tortoise_pkg::*;
#(
  parameter int FIFO_DEPTH = BTB_UPD_FIFO_DEPTH,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  addr_t [1:0]     req_pc_i,
  input  addr_t [1:0]     req_target_i,
  output logic            fb_valid_o,
  output addr_t           fb_branch_pc_o,
  output addr_t           fb_target_addr_o,
  output logic            btb_flush_o,
  output logic [CW-1:0]   occupancy_o
);

  btb_update_t [1:0] wdata;
  btb_update_t       head;
  btb_update_t       last_q;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic              pop;
  logic              fb_valid;
  logic              rr_q;
  logic              contended;

  assign wdata[0] = '{pc: req_pc_i[0], target: req_target_i[0]};
  assign wdata[1] = '{pc: req_pc_i[1], target: req_target_i[1]};

  assign fb_valid = (count != '0) & ~debug_mode_i & ~flush_i;
  assign pop      = fb_valid;
  assign free     = CW'(FIFO_DEPTH) - count + CW'(pop);

  // Grant: flush blocks, debug swallows, otherwise fit by free slots.
  always_comb begin
    ready = 2'b11;
    if (flush_i) begin
      ready = 2'b00;
    end else if (debug_mode_i) begin
      ready = 2'b11;
    end else if (free == '0) begin
      ready = 2'b00;
    end else if (free == CW'(1) && (&req_valid_i)) begin
      ready = rr_q ? 2'b10 : 2'b01;
    end
  end

  assign push      = req_valid_i & ready
                   & {2{~flush_i & ~debug_mode_i}};
  assign contended = (&req_valid_i) & (^push);

  // Round-robin pointer moves only when one of two rivals lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= 1'b0;
    else if (contended) rr_q <= ~rr_q;
  end

  // Remember the last presented update so idle outputs hold it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= '0;
    else if (pop) last_q <= head;
  end

  btb_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign req_ready_o      = ready;
  assign fb_valid_o       = fb_valid;
  assign fb_branch_pc_o   = fb_valid ? head.pc : last_q.pc;
  assign fb_target_addr_o = fb_valid ? head.target : last_q.target;
  assign btb_flush_o      = flush_i;
  assign occupancy_o      = count;

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Directed bench for btb_update_arbiter.
// Expected values are hand-derived per step.
module tb_btb_update_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             debug_mode_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_pc_i;
  logic [1:0][31:0] req_target_i;
  logic             fb_valid_o;
  logic [31:0]      fb_branch_pc_o;
  logic [31:0]      fb_target_addr_o;
  logic             btb_flush_o;
  logic [2:0]       occupancy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  btb_update_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .debug_mode_i     (debug_mode_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_pc_i         (req_pc_i),
    .req_target_i     (req_target_i),
    .fb_valid_o       (fb_valid_o),
    .fb_branch_pc_o   (fb_branch_pc_o),
    .fb_target_addr_o (fb_target_addr_o),
    .btb_flush_o      (btb_flush_o),
    .occupancy_o      (occupancy_o)
  );

  function automatic logic [31:0] tg(input logic [31:0] pc);
    return pc + 32'h0000_1000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [1:0] v, input logic [31:0] p0,
                     input logic [31:0] p1);
    req_valid_i     = v;
    req_pc_i[0]     = p0;
    req_pc_i[1]     = p1;
    req_target_i[0] = tg(p0);
    req_target_i[1] = tg(p1);
  endtask

  task automatic fb(input string tag, input logic v,
                    input logic [31:0] pc);
    chk({tag, ".valid"}, 64'(fb_valid_o), 64'(v));
    if (v) begin
      chk({tag, ".pc"}, 64'(fb_branch_pc_o), 64'(pc));
      chk({tag, ".tgt"}, 64'(fb_target_addr_o), 64'(tg(pc)));
    end
  endtask

  task automatic occ(input string tag, input int n);
    chk({tag, ".occ"}, 64'(occupancy_o), 64'(n));
  endtask

  task automatic rdy(input string tag, input logic [1:0] r);
    chk({tag, ".ready"}, 64'(req_ready_o), 64'(r));
  endtask

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    debug_mode_i = 1'b0;
    req(2'b00, 32'h0, 32'h0);
    #1;
    chk("rst.valid", 64'(fb_valid_o), 64'd0);
    chk("rst.pc", 64'(fb_branch_pc_o), 64'd0);
    chk("rst.tgt", 64'(fb_target_addr_o), 64'd0);
    occ("rst", 0);
    rdy("rst", 2'b11);
    chk("rst.bflush", 64'(btb_flush_o), 64'd0);
    @(posedge clk_i);
    #7;
    rst_ni = 1'b1;

    // single update
    req_valid_i     = 2'b01;
    req_pc_i[0]     = 32'h8000_0010;
    req_target_i[0] = 32'h8000_0400;
    #1;
    rdy("single", 2'b11);
    chk("single.pre", 64'(fb_valid_o), 64'd0);
    tick();
    req_valid_i = 2'b00;
    chk("single.valid", 64'(fb_valid_o), 64'd1);
    chk("single.pc", 64'(fb_branch_pc_o), 64'h8000_0010);
    chk("single.tgt", 64'(fb_target_addr_o), 64'h8000_0400);
    occ("single", 1);
    tick();
    chk("single.idle", 64'(fb_valid_o), 64'd0);
    chk("single.hold", 64'(fb_branch_pc_o), 64'h8000_0010);
    occ("single.end", 0);

    // dual burst
    req(2'b11, 32'h100, 32'h104);
    #1;
    rdy("burst0", 2'b11);
    tick();
    req(2'b11, 32'h108, 32'h10c);
    #1;
    rdy("burst1", 2'b11);
    fb("burst.d0", 1'b1, 32'h100);
    occ("burst.d0", 2);
    tick();
    req(2'b00, 32'h0, 32'h0);
    fb("burst.d1", 1'b1, 32'h104);
    occ("burst.d1", 3);
    tick();
    fb("burst.d2", 1'b1, 32'h108);
    tick();
    fb("burst.d3", 1'b1, 32'h10c);
    occ("burst.d3", 1);
    tick();
    fb("burst.end", 1'b0, 32'h0);
    occ("burst.end", 0);

    // contention
    req(2'b11, 32'h200, 32'h204);
    tick();
    req(2'b11, 32'h208, 32'h20c);
    tick();
    req(2'b00, 32'h0, 32'h0);
    debug_mode_i = 1'b1;
    occ("cont.fill", 3);
    #1;
    fb("cont.dbg", 1'b0, 32'h0);
    tick();
    occ("cont.hold", 3);
    debug_mode_i = 1'b0;
    req(2'b11, 32'h300, 32'h304);
    #1;
    rdy("cont.free2", 2'b11);
    tick();
    occ("cont.full", 4);
    fb("cont.h0", 1'b1, 32'h208);
    req(2'b11, 32'h308, 32'h30c);
    #1;
    rdy("cont.rr0", 2'b01);
    tick();
    fb("cont.h1", 1'b1, 32'h20c);
    req(2'b11, 32'h310, 32'h30c);
    #1;
    rdy("cont.rr1", 2'b10);
    tick();
    fb("cont.h2", 1'b1, 32'h300);
    req(2'b01, 32'h310, 32'h0);
    #1;
    chk("cont.single", 64'(req_ready_o[0]), 64'd1);
    tick();
    req(2'b00, 32'h0, 32'h0);
    fb("cont.h3", 1'b1, 32'h304);
    occ("cont.h3", 4);
    tick();
    fb("cont.h4", 1'b1, 32'h308);
    tick();
    fb("cont.h5", 1'b1, 32'h30c);
    tick();
    fb("cont.h6", 1'b1, 32'h310);
    tick();
    fb("cont.end", 1'b0, 32'h0);
    occ("cont.end", 0);

    // debug drop
    req(2'b11, 32'h400, 32'h404);
    tick();
    debug_mode_i = 1'b1;
    req(2'b10, 32'h0, 32'h408);
    #1;
    chk("dbg.ready1", 64'(req_ready_o[1]), 64'd1);
    fb("dbg.fb", 1'b0, 32'h0);
    tick();
    req(2'b00, 32'h0, 32'h0);
    occ("dbg.hold", 2);
    chk("dbg.fb2", 64'(fb_valid_o), 64'd0);
    tick();
    debug_mode_i = 1'b0;
    #1;
    fb("dbg.x0", 1'b1, 32'h400);
    tick();
    fb("dbg.x1", 1'b1, 32'h404);
    tick();
    fb("dbg.end", 1'b0, 32'h0);
    occ("dbg.end", 0);

    // flush
    req(2'b11, 32'h500, 32'h504);
    tick();
    req(2'b11, 32'h508, 32'h50c);
    tick();
    occ("fl.pre", 3);
    flush_i = 1'b1;
    req(2'b11, 32'h510, 32'h514);
    #1;
    chk("fl.bflush", 64'(btb_flush_o), 64'd1);
    rdy("fl", 2'b00);
    fb("fl.c0", 1'b0, 32'h0);
    tick();
    flush_i = 1'b0;
    req(2'b00, 32'h0, 32'h0);
    occ("fl.post", 0);
    fb("fl.c1", 1'b0, 32'h0);
    chk("fl.bflush0", 64'(btb_flush_o), 64'd0);
    tick();
    fb("fl.c2", 1'b0, 32'h0);

    // async reset mid-drain
    req(2'b01, 32'h600, 32'h0);
    tick();
    req(2'b00, 32'h0, 32'h0);
    fb("ar.pre", 1'b1, 32'h600);
    #2;
    rst_ni = 1'b0;
    #1;
    fb("ar.rst", 1'b0, 32'h0);
    chk("ar.pc", 64'(fb_branch_pc_o), 64'd0);
    chk("ar.tgt", 64'(fb_target_addr_o), 64'd0);
    occ("ar.rst", 0);
    #2;
    rst_ni = 1'b1;
    req(2'b01, 32'h700, 32'h0);
    #1;
    rdy("ar.ready", 2'b11);
    tick();
    req(2'b00, 32'h0, 32'h0);
    fb("ar.new", 1'b1, 32'h700);
    tick();
    occ("ar.end", 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
